display_scan_ctrl: RTL and testbench

//  Upstream driver of the 3-to-8 select decoder. Multiplexes eight 4-bit digits onto one shared display bus.

---
 rtl/display_scan_ctrl_pkg.sv | 22 ++
 rtl/display_scan_ctrl_if.sv | 29 ++
 rtl/display_scan_ctrl_slot_timer.sv | 44 ++++
 rtl/display_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller.
// Holds the FSM state encoding, the bus widths used by the interface and
// the top, and a helper that picks one 4-bit digit out of a 32-bit frame.
package display_scan_ctrl_pkg;

  localparam int DIGIT_W = 3;
  localparam int NIB_W   = 4;
  localparam int FRAME_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // Digit d of a frame lives in bits [4d+3:4d].
  function automatic logic [NIB_W-1:0] pick_nibble(input logic [FRAME_W-1:0] frame,
                                                   input logic [DIGIT_W-1:0] idx);
    return frame[idx*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bus between a frame source / display decoder and display_scan_ctrl.
// Inputs:  iRun (scan enable), iLoad/iData (frame valid + frame).
// Outputs: oReady (shadow buffer free), oSel/oSelEn (decoder index and
//          enable), oNibble (digit value), oFrameDone (end-of-frame pulse).
// The master modport is the side that drives iRun/iLoad/iData; the slave
// modport is the scan controller itself.
interface display_scan_ctrl_if;
  import display_scan_ctrl_pkg::*;

  logic               iRun;
  logic               iLoad;
  logic [FRAME_W-1:0] iData;
  logic               oReady;
  logic [DIGIT_W-1:0] oSel;
  logic               oSelEn;
  logic [NIB_W-1:0]   oNibble;
  logic               oFrameDone;

  modport master (
    output iRun, iLoad, iData,
    input  oReady, oSel, oSelEn, oNibble, oFrameDone
  );

  modport slave (
    input  iRun, iLoad, iData,
    output oReady, oSel, oSelEn, oNibble, oFrameDone
  );

endinterface

// File: rtl/display_scan_ctrl_slot_timer.sv
// Slot timer for the display scan controller.
// Counts 0..SLOT_CYCLES-1 and wraps; held at 0 while iClear is high.
// Ports: iClk, iRst_n (synchronous, active low), iClear (force count to 0),
//        oBlankEnd (count is at the last blank cycle), oSlotEnd (count is at
//        the last cycle of the slot), oSlotEndNext (next count will be the
//        last cycle of the slot, used to register end-of-frame pulses).
module scan_slot_timer #(
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClear,
  output logic oBlankEnd,
  output logic oSlotEnd,
  output logic oSlotEndNext
);

  localparam int TICK_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_d;

  assign oBlankEnd    = (tick_q == TICK_W'(BLANK_CYCLES - 1));
  assign oSlotEnd     = (tick_q == TICK_W'(SLOT_CYCLES - 1));
  assign oSlotEndNext = (tick_q == TICK_W'(SLOT_CYCLES - 2));

  // Wrap at the end of the slot so the count never leaves 0..SLOT_CYCLES-1.
  always_comb begin
    tick_d = tick_q + TICK_W'(1);
    if (iClear || oSlotEnd) begin
      tick_d = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Display scan controller: drives the 3-to-8 select decoder of a shared
// multiplexed display. Each digit slot starts with a blanking interval
// (decoder disabled) before the decoder is enabled, so the digit index only
// ever changes while the display is dark. Frames arrive through a
// ready/valid handshake into a shadow register and are copied into the
// active register only at a frame boundary or while idle.
// Ports: iClk, iRst_n (synchronous, active low), bus (slave modport of
//        display_scan_ctrl_if carrying the run/load inputs and all outputs).
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int NUM_DIGITS   = 8
) (
  input  logic                iClk,
  input  logic                iRst_n,
  display_scan_ctrl_if.slave  bus
);

  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

  scan_state_e        state_q, state_d;
  logic [DIGIT_W-1:0] sel_q, sel_d;
  logic               sel_en_q, sel_en_d;
  logic [NIB_W-1:0]   nibble_q, nibble_d;
  logic               frame_done_q, frame_done_d;
  logic               ready_q, ready_d;
  logic               pending_q, pending_d;
  logic [FRAME_W-1:0] active_q, active_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;

  logic blank_end;
  logic slot_end;
  logic slot_end_next;
  logic timer_clear;
  logic boundary;
  logic accept;
  logic swap;
  logic load_nibble;

  // The timer only runs while scanning; leaving or sitting in IDLE parks it
  // at 0 so every restart gets a full blanking interval.
  assign timer_clear = (state_q == ST_IDLE) || !bus.iRun;

  scan_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iClear       (timer_clear),
    .oBlankEnd    (blank_end),
    .oSlotEnd     (slot_end),
    .oSlotEndNext (slot_end_next)
  );

  // A boundary is the edge that ends the last slot of a frame while the scan
  // keeps running. Frames swap there, or on any edge while idle.
  assign boundary = (state_q == ST_SHOW) && slot_end && (sel_q == LAST_DIGIT) && bus.iRun;
  assign accept   = bus.iLoad && ready_q;
  assign swap     = pending_q && (boundary || (state_q == ST_IDLE));

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      sel_en_q     <= 1'b0;
      nibble_q     <= '0;
      frame_done_q <= 1'b0;
      ready_q      <= 1'b1;
      pending_q    <= 1'b0;
      active_q     <= '0;
      shadow_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_en_q     <= sel_en_d;
      nibble_q     <= nibble_d;
      frame_done_q <= frame_done_d;
      ready_q      <= ready_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    load_nibble  = 1'b0;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    ready_d      = ready_q;

    unique case (state_q)
      ST_IDLE:  if (bus.iRun) state_d = ST_BLANK;
      ST_BLANK: if (blank_end) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end) state_d = ST_BLANK;
      default:  state_d = ST_IDLE;
    endcase
    if (!bus.iRun) begin
      state_d = ST_IDLE;
    end

    // ready is never high while a frame is pending, so swap and accept
    // cannot happen on the same edge.
    if (swap) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      ready_d   = 1'b1;
    end
    if (accept) begin
      shadow_d  = bus.iData;
      pending_d = 1'b1;
      ready_d   = 1'b0;
    end

    // The index moves only on edges that (re)enter a blanking interval or go
    // idle, so it is always stable while the decoder is enabled.
    if ((state_d == ST_IDLE) || (state_q == ST_IDLE)) begin
      sel_d       = '0;
      load_nibble = 1'b1;
    end else if ((state_q == ST_SHOW) && slot_end) begin
      sel_d       = (sel_q == LAST_DIGIT) ? '0 : sel_q + DIGIT_W'(1);
      load_nibble = 1'b1;
    end

    // Uses active_d so digit 0 of a freshly swapped frame is shown at once.
    nibble_d = load_nibble ? pick_nibble(active_d, sel_d) : nibble_q;

    sel_en_d = (state_d == ST_SHOW);

    // Registered one cycle ahead so the pulse lands on the final tick of the
    // last slot; SHOW always covers that tick, so this also keeps it out of IDLE.
    frame_done_d = (state_d == ST_SHOW) && slot_end_next && (sel_q == LAST_DIGIT);
  end

  assign bus.oSel       = sel_q;
  assign bus.oSelEn     = sel_en_q;
  assign bus.oNibble    = nibble_q;
  assign bus.oFrameDone = frame_done_q;
  assign bus.oReady     = ready_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl. Two instances (8 digits and 3 digits)
// share the same inputs; each is compared every cycle with a positional
// model that derives the expected outputs from the cycle count since the
// scan started and from a simple frame/shadow/pending bookkeeping.
module tb_display_scan_ctrl;

  localparam int SLOT  = 6;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        load;
  logic [31:0] data;

  int check_count = 0;
  int error_count = 0;

  // Model state, index 0 = 8-digit instance, index 1 = 3-digit instance.
  int          m_num[2];
  int          m_pos[2];
  bit          m_running[2];
  bit          m_pending[2];
  logic [31:0] m_active[2];
  logic [31:0] m_shadow[2];

  always #5 clk = ~clk;

  display_scan_ctrl_if bus8();
  display_scan_ctrl_if bus3();

  assign bus8.iRun  = run;
  assign bus8.iLoad = load;
  assign bus8.iData = data;
  assign bus3.iRun  = run;
  assign bus3.iLoad = load;
  assign bus3.iData = data;

  display_scan_ctrl #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK),
    .NUM_DIGITS   (8)
  ) dut8 (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus8)
  );

  display_scan_ctrl #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK),
    .NUM_DIGITS   (3)
  ) dut3 (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus3)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Advances the model of instance i by one clock edge using the current inputs.
  task automatic modelEdge(input int i);
    int frame_len;
    bit boundary;
    bit swap;
    bit accept;
    frame_len = SLOT * m_num[i];
    if (!rst_n) begin
      m_running[i] = 1'b0;
      m_pos[i]     = 0;
      m_pending[i] = 1'b0;
      m_active[i]  = '0;
      m_shadow[i]  = '0;
    end else begin
      boundary = m_running[i] && run && (m_pos[i] == frame_len - 1);
      swap     = m_pending[i] && (boundary || !m_running[i]);
      accept   = load && !m_pending[i];
      if (swap) begin
        m_active[i]  = m_shadow[i];
        m_pending[i] = 1'b0;
      end
      if (accept) begin
        m_shadow[i]  = data;
        m_pending[i] = 1'b1;
      end
      if (!run) begin
        m_running[i] = 1'b0;
        m_pos[i]     = 0;
      end else if (!m_running[i]) begin
        m_running[i] = 1'b1;
        m_pos[i]     = 0;
      end else begin
        m_pos[i] = (m_pos[i] + 1) % frame_len;
      end
    end
  endtask

  // Compares every output of one instance with the model.
  task automatic checkDut(input int i, input logic [2:0] sel, input logic sel_en,
                          input logic [3:0] nibble, input logic ready, input logic frame_done);
    int          exp_sel;
    bit          exp_en;
    bit          exp_fd;
    logic [31:0] shifted;
    string       pfx;
    pfx = $sformatf("d%0d", m_num[i]);
    exp_sel = 0;
    exp_en  = 1'b0;
    exp_fd  = 1'b0;
    if (m_running[i]) begin
      exp_sel = m_pos[i] / SLOT;
      exp_en  = (m_pos[i] % SLOT) >= BLANK;
      exp_fd  = (m_pos[i] == SLOT * m_num[i] - 1);
    end
    shifted = m_active[i] >> (4 * exp_sel);
    checkOutput({pfx, "_sel"}, 32'(sel), 32'(exp_sel));
    checkOutput({pfx, "_selEn"}, 32'(sel_en), 32'(exp_en));
    checkOutput({pfx, "_nibble"}, 32'(nibble), 32'(shifted[3:0]));
    checkOutput({pfx, "_ready"}, 32'(ready), 32'(!m_pending[i]));
    checkOutput({pfx, "_frameDone"}, 32'(frame_done), 32'(exp_fd));
  endtask

  // Holds the given inputs for a number of cycles, checking after each edge.
  task automatic applyStimulus(input bit r, input bit ru, input bit l,
                               input logic [31:0] d, input int cycles);
    rst_n = r;
    run   = ru;
    load  = l;
    data  = d;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      modelEdge(0);
      modelEdge(1);
      #1;
      checkDut(0, bus8.oSel, bus8.oSelEn, bus8.oNibble, bus8.oReady, bus8.oFrameDone);
      checkDut(1, bus3.oSel, bus3.oSelEn, bus3.oNibble, bus3.oReady, bus3.oFrameDone);
    end
  endtask

  initial begin
    bit found;
    bit cur_run;
    m_num[0] = 8;
    m_num[1] = 3;
    for (int i = 0; i < 2; i++) begin
      m_pos[i]     = 0;
      m_running[i] = 1'b0;
      m_pending[i] = 1'b0;
      m_active[i]  = '0;
      m_shadow[i]  = '0;
    end
    rst_n = 1'b0;
    run   = 1'b0;
    load  = 1'b0;
    data  = '0;

    // Reset held with random inputs.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1);
    end

    // Idle load, then two full frames of scanning.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h7654_3210, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, $urandom, 3);
    applyStimulus(1'b1, 1'b1, 1'b0, $urandom, 2 * 8 * SLOT + 4);

    // Mid-frame load, second load while busy must be ignored.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFEDC_BA98, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0000, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, $urandom, 2 * 8 * SLOT);

    // Drop run while digit 5 is shown, then restart.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (bus8.oSel == 3'd5 && bus8.oSelEn) begin
        found = 1'b1;
      end else begin
        applyStimulus(1'b1, 1'b1, 1'b0, $urandom, 1);
      end
    end
    checkOutput("wait_digit5", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, $urandom, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, $urandom, 20);

    // Reset pulse during SHOW with a frame pending.
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (bus8.oSelEn) begin
        found = 1'b1;
      end else begin
        applyStimulus(1'b1, 1'b1, 1'b0, $urandom, 1);
      end
    end
    checkOutput("wait_show", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h1357_9BDF, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, $urandom, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, $urandom, 8 * SLOT + 6);

    // Random traffic: mostly running, occasional run toggles, loads and resets.
    cur_run = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) cur_run = !cur_run;
      applyStimulus(1'($urandom_range(0, 299) != 0), cur_run,
                    1'($urandom_range(0, 7) == 0), $urandom, 1);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
